mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port, synchronous-read, byte-write-enabled 32-bit word memory between the instruction-fetch requester (I) and the load/store requester (D). Each cycle it grants at most one request, drives the memory port, and routes the 1-cycle-latency read data back to the owner. It sits between the core front-end/LSU and the unified memory array. It also supports fetch flush on redirect.

Parameters:
ADDR_W, 32, request address width (byte address)
DATA_W, 32, word width; fixed at 32 (4 byte enables)
STARVE_MAX, 4, max consecutive I losses before forced I grant (optional feature only)

Ports:
clk  in  1  single clock; all state on posedge
rst  in  1  asynchronous, active-low reset
i_req_valid  in  1  fetch request valid
i_req_addr  in  ADDR_W  fetch byte address, 4B aligned
i_req_ready  out  1  fetch request accepted this cycle
i_flush  in  1  drop any in-flight fetch response
i_resp_valid  out  1  fetch data valid
i_resp_data  out  32  fetched word
d_req_valid  in  1  load/store request valid
d_req_addr  in  ADDR_W  data byte address
d_req_we  in  4  byte write enables; 0 = load
d_req_wdata  in  32  store data
d_req_ready  out  1  data request accepted
d_resp_valid  out  1  load data / store ack valid
d_resp_data  out  32  load word; 0 for store ack
mem_en  out  1  memory access this cycle
mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
mem_we  out  4  byte enables to memory
mem_wdata  out  32  store data to memory
mem_rdata  in  32  memory read data, valid cycle after mem_en

Behaviour:
- Reset (rst=0, async): owner_q=NONE, last_grant_q=I, starve_cnt=0; i_resp_valid=d_resp_valid=0, resp data=0. A response pending at reset assertion is discarded; it is never emitted after release.
- Grant is combinational from the valids: only one valid -> grant it; both valid -> the side not in last_grant_q (round-robin). Grant sets the corresponding *_req_ready=1 in the same cycle; the other ready=0.
- Accept = valid & ready. On accept: mem_en=1, mem_addr = addr with [1:0] cleared, mem_we = d_req_we for D, 0 for I; mem_wdata = d_req_wdata. No grant -> mem_en=0, mem_we=0.
- Stores commit at the accept edge. Memory is read-first, so the returned data is the pre-write word, which is discarded for stores.
- owner_q <= granted side (I, D_LOAD, D_STORE) or NONE; last_grant_q updates only on accept.
- Response cycle (cycle N+1 after accept at N): owner I -> i_resp_valid=1, i_resp_data=mem_rdata; D_LOAD -> d_resp_valid=1, d_resp_data=mem_rdata; D_STORE -> d_resp_valid=1, d_resp_data=0. Responses have no backpressure; the requester must sink them.
- Throughput: one accept per cycle, back-to-back allowed. A new accept in the response cycle is legal; owner_q pipelines.
- i_flush=1 in cycle N+1 with owner I: i_resp_valid is forced 0. i_flush in the accept cycle N also kills the response due at N+1. i_flush has no effect on D or on grant.
- Misaligned addresses (addr[1:0]!=0) are silently word-aligned; no error.

Optional Feature:
ARB_STARVE_LIMIT_EN:
- Defined: fixed priority D over I. starve_cnt increments each cycle I is valid and not granted; it resets to 0 when I is granted or I is not valid. When starve_cnt==STARVE_MAX, I wins the next contended cycle.
- Undefined: pure round-robin as above; starve_cnt absent.

Test Plan:
- Reset: rst=0 mid-traffic with a load accepted at the previous edge -> d_resp_valid stays 0 through release; all outputs 0.
- I-only read: i_req_addr=0x10 with mem word[4]=0xDEADBEEF -> i_req_ready=1, mem_addr=0x10, mem_we=0; next cycle i_resp_valid=1, data 0xDEADBEEF.
- Store then load: store we=4'b0011, wdata=0x12345678 at 0x20 (old 0xAABBCCDD) -> d_resp_valid with data 0 next cycle; load 0x20 the cycle after -> 0xAABB5678.
- Contention, round-robin: both valid for 4 cycles -> grants D,I,D,I (last_grant=I at reset); each response routed to the correct side only.
- Flush: I accepted at N, i_flush=1 at N+1 -> no i_resp_valid; a D accept at N+1 still responds at N+2.
- ARB_STARVE_LIMIT_EN, STARVE_MAX=4, both valid continuously -> D granted 4 cycles, I on 5th, pattern repeats.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one synchronous-read, byte-write 32-bit memory port
// between instruction fetch (I) and load/store (D); routes 1-cycle read data.
// Optional macro ARB_STARVE_LIMIT_EN: D-over-I priority with I starvation cap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  input  logic              i_flush,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [3:0]        d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_I       = 2'd1,
    OWN_D_LOAD  = 2'd2,
    OWN_D_STORE = 2'd3
  } owner_e;

  owner_e            owner_q;
  owner_e            owner_d;
  logic              grant_i;
  logic              grant_d;
  logic [ADDR_W-1:0] sel_addr;

  // A zero starvation cap would make the limit meaningless.
  if (STARVE_MAX < 1) begin : g_starve_max_invalid
  end

`ifdef ARB_STARVE_LIMIT_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_i = i_req_valid & (~d_req_valid | starved);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (i_req_valid && !grant_i) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  logic last_grant_d_q;  // 0: last accept went to I, 1: to D

  assign grant_i = i_req_valid & (~d_req_valid | last_grant_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_d_q <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_grant_d_q <= grant_d;
    end
  end
`endif

  assign grant_d     = d_req_valid & ~grant_i;
  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  assign sel_addr  = grant_d ? d_req_addr : i_req_addr;
  assign mem_en    = grant_i | grant_d;
  assign mem_addr  = mem_en ? (sel_addr & ~ADDR_W'(3)) : '0;
  assign mem_we    = grant_d ? d_req_we : 4'b0000;
  assign mem_wdata = d_req_wdata;

  // A fetch flushed in its own accept cycle is tracked as no owner.
  always_comb begin
    owner_d = OWN_NONE;
    if (grant_i && !i_flush) begin
      owner_d = OWN_I;
    end else if (grant_d) begin
      owner_d = (|d_req_we) ? OWN_D_STORE : OWN_D_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign i_resp_valid = (owner_q == OWN_I) & ~i_flush;
  assign i_resp_data  = i_resp_valid ? mem_rdata : '0;
  assign d_resp_valid = (owner_q == OWN_D_LOAD) | (owner_q == OWN_D_STORE);
  assign d_resp_data  = (owner_q == OWN_D_LOAD) ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural read-first memory.
`default_nettype none

module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic              i_flush;
  logic              i_resp_valid;
  logic [31:0]       i_resp_data;
  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic [3:0]        d_req_we;
  logic [31:0]       d_req_wdata;
  logic              d_req_ready;
  logic              d_resp_valid;
  logic [31:0]       d_resp_data;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  logic              pl_en = 1'b0;
  logic [5:0]        pl_idx = '0;
  logic [31:0]       pl_val = '0;
  logic [31:0]       mem [0:63];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_flush(i_flush), .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Read-first synchronous memory with byte enables; preload port for setup.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr[7:2]];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_flush     = 1'b0;
    d_req_valid = 1'b0;
    d_req_addr  = '0;
    d_req_we    = 4'b0000;
    d_req_wdata = '0;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_idx = 6'(idx);
    pl_val = val;
    pl_en  = 1'b1;
    next_cycle();
    pl_en  = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    idle_inputs();
    next_cycle();
    next_cycle();
    n_cmp++;
    if (i_q.size() !== 0 || d_q.size() !== 0) begin
      n_bad++;
      $display("FAIL %s drain: outstanding i=%0d d=%0d, required 0/0", name, i_q.size(), d_q.size());
    end
    i_q.delete();
    d_q.delete();
  endtask

  task automatic monitor();
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (i_resp_valid) begin
        n_cmp++;
        if (i_q.size() == 0) begin
          n_bad++;
          $display("FAIL i_resp unexpected: got valid data %h, required no response", i_resp_data);
        end else begin
          exp = i_q.pop_front();
          if (i_resp_data !== exp) begin
            n_bad++;
            $display("FAIL i_resp data: got %h, required %h", i_resp_data, exp);
          end
        end
      end
      if (d_resp_valid) begin
        n_cmp++;
        if (d_q.size() == 0) begin
          n_bad++;
          $display("FAIL d_resp unexpected: got valid data %h, required no response", d_resp_data);
        end else begin
          exp = d_q.pop_front();
          if (d_resp_data !== exp) begin
            n_bad++;
            $display("FAIL d_resp data: got %h, required %h", d_resp_data, exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    d_req_valid = 1'b1;
    d_req_addr  = 32'h20;
    d_req_we    = 4'b0000;
    next_cycle();
    // Load accepted at the previous edge; its response must never appear.
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({i_resp_valid, d_resp_valid, i_req_ready, d_req_ready, mem_en} !== 5'b0 ||
        i_resp_data !== 32'h0 || d_resp_data !== 32'h0 || mem_we !== 4'h0) begin
      n_bad++;
      $display("FAIL reset outputs: got iv=%b dv=%b id=%h dd=%h en=%b we=%h, required all 0",
               i_resp_valid, d_resp_valid, i_resp_data, d_resp_data, mem_en, mem_we);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_resp_valid !== 1'b0 || i_resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset release: got dv=%b iv=%b, required 0/0", d_resp_valid, i_resp_valid);
    end
    drain_and_check("reset");
  endtask

  task automatic test_i_read();
    preload(4, 32'hDEADBEEF);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    i_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    n_cmp++;
    if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0 || mem_en !== 1'b1 ||
        mem_addr !== 32'h10 || mem_we !== 4'h0) begin
      n_bad++;
      $display("FAIL i_read port: got ir=%b dr=%b en=%b addr=%h we=%h, required 1 0 1 00000010 0",
               i_req_ready, d_req_ready, mem_en, mem_addr, mem_we);
    end
    next_cycle();
    i_req_addr = 32'h13;
    i_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    n_cmp++;
    if (mem_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL misaligned addr: got %h, required 00000010", mem_addr);
    end
    next_cycle();
    drain_and_check("i_read");
  endtask

  task automatic test_store_load();
    preload(8, 32'hAABBCCDD);
    d_req_valid = 1'b1;
    d_req_addr  = 32'h20;
    d_req_we    = 4'b0011;
    d_req_wdata = 32'h12345678;
    d_q.push_back(32'h0);
    @(negedge clk);
    n_cmp++;
    if (d_req_ready !== 1'b1 || mem_we !== 4'b0011 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h20) begin
      n_bad++;
      $display("FAIL store port: got dr=%b we=%b wd=%h addr=%h, required 1 0011 12345678 00000020",
               d_req_ready, mem_we, mem_wdata, mem_addr);
    end
    next_cycle();
    d_req_we = 4'b0000;
    d_q.push_back(32'hAABB5678);
    @(negedge clk);
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 4'b0000) begin
      n_bad++;
      $display("FAIL load port: got en=%b we=%b, required 1 0000", mem_en, mem_we);
    end
    next_cycle();
    drain_and_check("store_load");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) preload(20 + k, 32'hC000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) begin
      i_req_valid = 1'b1;
      i_req_addr  = 32'h50 + 32'(4 * k);
      i_q.push_back(32'hC000_0000 + 32'(k));
      @(negedge clk);
      n_cmp++;
      if (i_req_ready !== 1'b1 || mem_addr !== i_req_addr) begin
        n_bad++;
        $display("FAIL back_to_back %0d: got ir=%b addr=%h, required 1 %h", k, i_req_ready, mem_addr, i_req_addr);
      end
      next_cycle();
    end
    drain_and_check("back_to_back");
  endtask

  task automatic test_contention();
    logic exp_i;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    preload(16, 32'h1A1A1A1A);
    preload(32, 32'hD0D0D0D0);
    for (int k = 0; k < 10; k++) begin
      i_req_valid = 1'b1;
      i_req_addr  = 32'h40;
      d_req_valid = 1'b1;
      d_req_addr  = 32'h80;
      d_req_we    = 4'b0000;
`ifdef ARB_STARVE_LIMIT_EN
      exp_i = ((k % 5) == 4);
`else
      exp_i = ((k % 2) == 1);
`endif
      if (exp_i) i_q.push_back(32'h1A1A1A1A);
      else       d_q.push_back(32'hD0D0D0D0);
      @(negedge clk);
      n_cmp++;
      if (i_req_ready !== exp_i || d_req_ready !== !exp_i ||
          mem_addr !== (exp_i ? 32'h40 : 32'h80)) begin
        n_bad++;
        $display("FAIL contention cycle %0d: got ir=%b dr=%b addr=%h, required ir=%b dr=%b",
                 k, i_req_ready, d_req_ready, mem_addr, exp_i, !exp_i);
      end
      next_cycle();
    end
    drain_and_check("contention");
  endtask

  task automatic test_flush();
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    @(negedge clk);
    n_cmp++;
    if (i_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush accept: got ir=%b, required 1", i_req_ready);
    end
    next_cycle();
    idle_inputs();
    i_flush     = 1'b1;
    d_req_valid = 1'b1;
    d_req_addr  = 32'h20;
    d_q.push_back(32'hAABB5678);
    @(negedge clk);
    n_cmp++;
    if (i_resp_valid !== 1'b0 || d_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush resp cycle: got iv=%b dr=%b, required 0 1", i_resp_valid, d_req_ready);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    i_flush     = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (i_req_ready !== 1'b1 || mem_en !== 1'b1) begin
      n_bad++;
      $display("FAIL flush at accept grant: got ir=%b en=%b, required 1 1", i_req_ready, mem_en);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (i_resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush at accept resp: got iv=%b, required 0", i_resp_valid);
    end
    drain_and_check("flush");
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_i_read();
    test_store_load();
    test_back_to_back();
    test_contention();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
